// File: rtl/adc_bcd_converter.sv
// Purpose: average 2^AVG_LOG2 ADC samples and convert the mean to four BCD digits.
// Latency: digits/o_BCD_VALID appear 15 cycles after the block's final sample is accepted.
// Backpressure: none; sampling never stalls, a one-deep pending mean is overwritten (o_overrun).
module adc_bcd_converter #(
   parameter int AVG_LOG2 = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] i_DATA,
   input  logic        i_DATA_VALID,
   output logic [3:0]  ones,
   output logic [3:0]  tens,
   output logic [3:0]  hundreds,
   output logic [3:0]  thousands,
   output logic        o_BCD_VALID,
   output logic        o_busy,
   output logic        o_overrun
);

   // Accumulator is wide enough that 2^AVG_LOG2 full-scale samples never overflow.
   localparam int ACC_W = 12 + AVG_LOG2;
   // A zero-bit counter is not legal, so the no-averaging build keeps one bit tied at 0.
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state;
   logic               valid_q;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic [11:0]        pend_mean;
   logic               pend_rdy;
   logic [27:0]        sreg;
   logic [27:0]        sreg_adj;
   logic [3:0]         iter;

   logic               accept;
   logic               last_sample;
   logic               consume;
   logic [ACC_W-1:0]   acc_sum;
   logic [11:0]        block_mean;

   // Only a rising edge of the strobe counts, so a level-held valid is one sample.
   assign accept      = i_DATA_VALID & ~valid_q;
   assign last_sample = accept && (cnt == CNT_LAST);
   assign acc_sum     = acc + ACC_W'(i_DATA);
   // Plain truncation of the block sum; no rounding term is added.
   assign block_mean  = 12'(acc_sum >> AVG_LOG2);
   // The FSM takes the pending mean in the same cycle it leaves IDLE.
   assign consume     = (state == S_IDLE) && pend_rdy;
   assign o_busy      = (state != S_IDLE);

   // Register the strobe for edge detection; reset clears it so a held strobe re-triggers.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= i_DATA_VALID;
      end
   end

   // Accumulate accepted samples; clear at the end of each block.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         if (cnt == CNT_LAST) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= acc_sum;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // One-entry pending mean; a new mean wins over a stale one, and a
   // same-cycle consume means nothing was lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_mean <= '0;
         pend_rdy  <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         o_overrun <= last_sample && pend_rdy && !consume;
         if (last_sample) begin
            pend_mean <= block_mean;
            pend_rdy  <= 1'b1;
         end else if (consume) begin
            pend_rdy  <= 1'b0;
         end
      end
   end

   // Double-dabble correction: every BCD nibble holding 5..9 gets +3 before the shift.
   always_comb begin
      sreg_adj = sreg;
      for (int i = 0; i < 4; i++) begin
         if (sreg[12 + 4*i +: 4] >= 4'd5) begin
            sreg_adj[12 + 4*i +: 4] = sreg[12 + 4*i +: 4] + 4'd3;
         end
      end
   end

   // Converter FSM: load, 12 shift-add-3 iterations, then publish the digits.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         sreg        <= '0;
         iter        <= '0;
         ones        <= '0;
         tens        <= '0;
         hundreds    <= '0;
         thousands   <= '0;
         o_BCD_VALID <= 1'b0;
      end else begin
         o_BCD_VALID <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pend_rdy) begin
                  sreg  <= {16'b0, pend_mean};
                  iter  <= '0;
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               sreg <= {sreg_adj[26:0], 1'b0};
               iter <= iter + 4'd1;
               if (iter == 4'd11) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               thousands   <= sreg[27:24];
               hundreds    <= sreg[23:20];
               tens        <= sreg[19:16];
               ones        <= sreg[15:12];
               o_BCD_VALID <= 1'b1;
               state       <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/adc_bcd_converter.md
# adc_bcd_converter

Downstream consumer of the SPI ADC reader's 12-bit sample stream. It averages a block of 2^AVG_LOG2 samples and converts the mean to four BCD digits with a sequential shift-add-3 (double-dabble) engine. Its digit outputs drive the 7-segment controller's ones/tens/hundreds/thousands inputs, so the display shows the live ADC reading (0000–4095).

## Interface
Parameters:
- AVG_LOG2, default 2: log2 of the samples averaged per result. Legal range 0–3; 0 means no averaging.

Ports:
- clk  in  1  system clock, the same domain as the SPI reader. There is only one clock.
- reset  in  1  synchronous, active-high reset.
- i_DATA  in  12  ADC sample from the SPI reader.
- i_DATA_VALID  in  1  sample strobe from the SPI reader. Level-tolerant: only its rising edge counts.
- ones  out  4  BCD units digit.
- tens  out  4  BCD tens digit.
- hundreds  out  4  BCD hundreds digit.
- thousands  out  4  BCD thousands digit (0–4).
- o_BCD_VALID  out  1  one-cycle pulse when the digit outputs update.
- o_busy  out  1  high while the converter FSM is outside IDLE.
- o_overrun  out  1  one-cycle pulse when a pending mean is overwritten before it is consumed.

## Operation
- Edge detect: `valid_q` is `i_DATA_VALID` registered. A sample is accepted in a cycle where `i_DATA_VALID=1` and `valid_q=0`. Holding valid high for several cycles gives exactly one acceptance.
- Accumulator:
  - Width is 12+AVG_LOG2 bits, with a sample counter of AVG_LOG2 bits.
  - Each accepted sample is added.
  - When the 2^AVG_LOG2-th sample of a block is accepted:
    - the mean `(acc + i_DATA) >> AVG_LOG2` is written to the pending register. This is truncation; there is no rounding.
    - `pend_rdy` is set.
    - the accumulator and counter clear.
  - The accumulator runs independently of the converter and never stalls.
- Pending register: one entry.
  - If a new mean arrives while `pend_rdy=1`, the new mean overwrites the old one and `o_overrun` pulses.
  - If the FSM consumes the pending mean in the same cycle that a new mean arrives, the new mean is stored with `pend_rdy=1` and there is no overrun.
- Converter FSM, three states:
  - IDLE: if `pend_rdy`, load a 28-bit shift register as {16'b0, mean}, clear `pend_rdy`, set iteration count to 0, go to SHIFT.
  - SHIFT:
    - Each cycle, add 3 to every BCD nibble that is ≥5, then shift left by 1.
    - After the 12th shift, go to DONE.
    - Exactly 12 cycles in SHIFT.
  - DONE: copy the upper 16 bits to thousands/hundreds/tens/ones, assert `o_BCD_VALID` (registered, visible next cycle), return to IDLE.
- Digit outputs hold their last value until the next DONE.
- Width rule: the maximum mean is 4095, so `thousands` never exceeds 4. Every nibble is always a legal BCD digit.

## Timing
- Let T be the cycle in which the final sample of a block is accepted. With the FSM in IDLE:
  - `pend_rdy` is visible in T+1.
  - SHIFT runs in T+2..T+13.
  - DONE is in T+14.
  - Digits update and `o_BCD_VALID` is high in T+15 only.
- `o_busy` is high in T+2..T+14.
- The minimum spacing between conversions is 14 cycles, from one IDLE load to the next.
- Reset values:
  - all digits 0;
  - `o_BCD_VALID`, `o_busy` and `o_overrun` all 0;
  - accumulator, counter, `pend_rdy` and `valid_q` all 0;
  - FSM in IDLE.
- Reset mid-conversion aborts the conversion: the partial result is discarded and digits return to 0 on the next cycle. A partial sample block is also discarded.
- If `i_DATA_VALID` is high during reset, no acceptance occurs. `valid_q` is cleared by reset, so if `i_DATA_VALID` is still high on the first cycle after reset, that cycle counts as a rising edge.

## Test plan
- Reset check: assert reset for 3 cycles with `i_DATA_VALID=1` → all outputs 0; first post-reset cycle counts as an edge.
- Averaging/truncation (AVG_LOG2=2): samples 1000, 1000, 1000, 1002 → in T+15, `o_BCD_VALID`=1 and digits read 1,0,0,0; the pulse lasts 1 cycle; `o_busy` is high for exactly 13 cycles.
- Extremes: four samples of 4095 → digits 4,0,9,5. Four samples of 0 → digits 0,0,0,0 with `o_BCD_VALID` still pulsing. Mixed block 9,9,9,9 → digits 0,0,0,9.
- Level-held strobe: `i_DATA_VALID` high for 6 cycles with 2048 → counted as one sample. Four such strobes → digits 2,0,4,8.
- Overrun (AVG_LOG2=0 build): accept 123, 456 and 789 on cycles 0, 3 and 6 → first result 0,1,2,3; 456 is overwritten by 789 with one `o_overrun` pulse; second result 0,7,8,9. Exactly two `o_BCD_VALID` pulses.
- Reset mid-conversion: assert reset in the 5th SHIFT cycle → digits stay 0 with no `o_BCD_VALID`; the next full block of 3210 ×4 → digits 3,2,1,0.
